// File: rtl/pmem_responder_pkg.sv
// Shared types for the physical-memory responder and the cache it serves:
// the RV32I address word, line geometry and the responder state encoding.
package rv32i_types;
  typedef logic [31:0] rv32i_word;
endpackage

package cache_types;
  localparam int LINE_BITS   = 256;
  localparam int OFFSET_BITS = 5;

  typedef logic [LINE_BITS-1:0] cache_line_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } pmem_state_t;
endpackage

// File: rtl/pmem_responder_line_array.sv
// Single-port line RAM with registered read. The read register keeps its
// value until the next read access.
module line_array #(
  parameter int INDEX_BITS = 8,
  parameter int LINE_BITS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] addr,
  input  logic [LINE_BITS-1:0]  wdata,
  output logic [LINE_BITS-1:0]  rdata
);

  logic [LINE_BITS-1:0] mem [2**INDEX_BITS];

  // A write whose commit edge coincides with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/pmem_responder.sv
// Physical-memory responder: services one whole-line read or write per request
// after a fixed latency. Build with PMEM_PROTOCOL_CHECK_EN for the pmem_err checker.
//
//  state | meaning
//  IDLE  | waiting for pmem_read/pmem_write; request is latched here
//  BUSY  | latency countdown, request inputs ignored
//  RESP  | pmem_resp high for this single cycle; array access happened on entry
//  DONE  | recovery cycle, requests ignored
module pmem_responder
  import cache_types::*;
  import rv32i_types::*;
#(
  parameter int LINE_BITS   = cache_types::LINE_BITS,
  parameter int OFFSET_BITS = cache_types::OFFSET_BITS,
  parameter int INDEX_BITS  = 8,
  parameter int READ_LAT    = 4,
  parameter int WRITE_LAT   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pmem_read,
  input  logic                 pmem_write,
  input  rv32i_word            pmem_address,
  input  logic [LINE_BITS-1:0] pmem_wdata,
  output logic [LINE_BITS-1:0] pmem_rdata,
  output logic                 pmem_resp,
  output logic                 pmem_err
);

  localparam int IDX_LO  = OFFSET_BITS;
  localparam int IDX_HI  = OFFSET_BITS + INDEX_BITS - 1;
  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam int RD_LOAD_I = (READ_LAT  >= 2) ? READ_LAT  - 2 : 0;
  localparam int WR_LOAD_I = (WRITE_LAT >= 2) ? WRITE_LAT - 2 : 0;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LOAD_I);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LOAD_I);
  localparam bit RD_DIRECT = (READ_LAT  < 2);
  localparam bit WR_DIRECT = (WRITE_LAT < 2);

  pmem_state_t state, next_state;

  logic [CNT_W-1:0]      cnt;
  logic                  op_wr_q;
  logic [INDEX_BITS-1:0] idx_q;
  logic [LINE_BITS-1:0]  wdata_q;

  logic                  req;
  logic                  req_wr;
  logic                  ram_en;
  logic                  ram_we;
  logic [INDEX_BITS-1:0] ram_idx;
  logic [LINE_BITS-1:0]  ram_wdata;

  // Read wins when both strobes are high.
  assign req    = pmem_read | pmem_write;
  assign req_wr = pmem_write & ~pmem_read;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req) begin
          next_state = (req_wr ? WR_DIRECT : RD_DIRECT) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          next_state = RESP;
        end
      end
      RESP:    next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // With a one-cycle latency the array is accessed on the sampling edge itself,
  // so the live request feeds the array instead of the latched copy.
  always_comb begin
    pmem_resp = (state == RESP);
    ram_en    = (next_state == RESP);
    ram_we    = (state == IDLE) ? req_wr : op_wr_q;
    ram_idx   = (state == IDLE) ? pmem_address[IDX_HI:IDX_LO] : idx_q;
    ram_wdata = (state == IDLE) ? pmem_wdata : wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == IDLE && req) begin
      cnt <= req_wr ? WR_LOAD : RD_LOAD;
    end else if (state == BUSY && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      op_wr_q <= req_wr;
      idx_q   <= pmem_address[IDX_HI:IDX_LO];
      wdata_q <= pmem_wdata;
    end
  end

  line_array #(
    .INDEX_BITS (INDEX_BITS),
    .LINE_BITS  (LINE_BITS)
  ) u_line_array (
    .clk   (clk),
    .rst   (rst),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_idx),
    .wdata (ram_wdata),
    .rdata (pmem_rdata)
  );

`ifdef PMEM_PROTOCOL_CHECK_EN
  rv32i_word addr_q;
  logic      err_q;
  logic      violation;

  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      addr_q <= pmem_address;
    end
  end

  always_comb begin
    violation = (pmem_read && pmem_write)
             || (state == BUSY && (!req || pmem_address != addr_q))
             || (state == DONE && req);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (violation) begin
      err_q <= 1'b1;
    end
  end

  assign pmem_err = err_q;
`else
  logic unused_addr;

  assign pmem_err    = 1'b0;
  assign unused_addr = ^{pmem_address[31:IDX_HI+1], pmem_address[IDX_LO-1:0]};
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Randomized bench for pmem_responder: a 4/4-latency instance and a 1/3-latency
// instance checked against a line-array model with cycle-accurate response timing.
module tb_pmem_responder;

  localparam int LB = 256;
  typedef logic [LB-1:0] line_t;

`ifdef PMEM_PROTOCOL_CHECK_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  line_t       wdata [2];
  line_t       rdata [2];
  logic        resp  [2];
  logic        err   [2];

  pmem_responder #(.READ_LAT(4), .WRITE_LAT(4)) dut_a (
    .clk(clk), .rst(rst), .pmem_read(rd[0]), .pmem_write(wr[0]),
    .pmem_address(addr[0]), .pmem_wdata(wdata[0]), .pmem_rdata(rdata[0]),
    .pmem_resp(resp[0]), .pmem_err(err[0])
  );

  pmem_responder #(.READ_LAT(1), .WRITE_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .pmem_read(rd[1]), .pmem_write(wr[1]),
    .pmem_address(addr[1]), .pmem_wdata(wdata[1]), .pmem_rdata(rdata[1]),
    .pmem_resp(resp[1]), .pmem_err(err[1])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state
  line_t mem       [2][256];
  bit    valid     [2][256];
  line_t rdata_exp [2];
  int    ready     [2];
  int    last_resp [2];
  int    viol      [2];

  int n_chk  = 0;
  int n_pass = 0;

  function automatic int rlat(input int w);
    return (w == 0) ? 4 : 1;
  endfunction

  function automatic int wlat(input int w);
    return (w == 0) ? 4 : 3;
  endfunction

  function automatic line_t err_exp(input int w);
    return line_t'(PROT && viol[w] >= 0 && cyc > viol[w]);
  endfunction

  task automatic check(input string tag, input line_t got, input line_t exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      rdata_exp[w] = '0;
      ready[w]     = cyc;
      last_resp[w] = -100;
      viol[w]      = -1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int w = 0; w < 2; w++) begin
        check($sformatf("idle_resp%0d", w), line_t'(resp[w]), '0);
        check($sformatf("idle_rdata%0d", w), rdata[w], rdata_exp[w]);
        check($sformatf("idle_err%0d", w), line_t'(err[w]), err_exp(w));
      end
      @(posedge clk); #1;
    end
  endtask

  // Drives one request starting in the current cycle, holds it until pmem_resp,
  // then drops it in the following cycle. Expected response cycle follows from
  // "sampled no earlier than previous resp + 2" plus the op latency.
  task automatic txn(input int w, input bit is_wr, input bit both,
                     input logic [31:0] a, input line_t d);
    int  start, exp_resp, got_resp, idx, lat;
    bit  rd_op;
    start = cyc;
    idx   = int'(a[12:5]);
    rd_op = !is_wr || both;
    lat   = rd_op ? rlat(w) : wlat(w);
    rd[w] = rd_op; wr[w] = is_wr || both; addr[w] = a; wdata[w] = d;
    if (viol[w] < 0 && (both || start == last_resp[w] + 1)) viol[w] = start;
    exp_resp = ((start > ready[w]) ? start : ready[w]) + lat;
    got_resp = -1;
    for (int k = 0; k < 40 && got_resp < 0; k++) begin
      @(negedge clk);
      check($sformatf("txn_err%0d", w), line_t'(err[w]), err_exp(w));
      if (resp[w]) got_resp = cyc;
      else begin
        @(posedge clk); #1;
      end
    end
    check($sformatf("resp_cycle%0d", w), line_t'(got_resp), line_t'(exp_resp));
    if (rd_op) rdata_exp[w] = mem[w][idx];
    else begin
      mem[w][idx]   = d;
      valid[w][idx] = 1'b1;
    end
    if (got_resp >= 0) begin
      check($sformatf("rdata%0d", w), rdata[w], rdata_exp[w]);
      last_resp[w] = got_resp;
    end else begin
      last_resp[w] = exp_resp;
    end
    ready[w] = last_resp[w] + 2;
    @(posedge clk); #1;
    rd[w] = 1'b0; wr[w] = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr(input int idx);
    logic [31:0] a;
    a       = $urandom;
    a[12:5] = idx[7:0];
    return a;
  endfunction

  function automatic line_t rand_line();
    return {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic random_run(input int w, input int n);
    int  idx, gap;
    bit  is_wr;
    for (int i = 0; i < n; i++) begin
      idx   = $urandom_range(0, 7);
      is_wr = !valid[w][idx] || ($urandom_range(0, 1) == 1);
      txn(w, is_wr, 1'b0, rand_addr(idx), rand_line());
      gap = $urandom_range(0, 2);
      if (gap > 0) idle(gap);
    end
  endtask

  initial begin
    line_t x3, y3;
    for (int w = 0; w < 2; w++) begin
      rd[w] = 1'b0; wr[w] = 1'b0; addr[w] = '0; wdata[w] = '0;
      for (int i = 0; i < 256; i++) valid[w][i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    idle(10);

    // Directed write/read through aliased offset bits
    txn(0, 1'b1, 1'b0, 32'h0000_0040, {32{8'hA5}});
    idle(1);
    txn(0, 1'b0, 1'b0, 32'h0000_005C, '0);
    idle(2);

    // Back-to-back reads: second request raised during the recovery cycle
    txn(0, 1'b1, 1'b0, 32'h0000_00E0, {8{32'h1234_5678}});
    idle(1);
    txn(0, 1'b0, 1'b0, 32'h0000_00E0, '0);
    txn(0, 1'b0, 1'b0, 32'h8000_0040, '0);
    idle(2);

    // Both strobes high: serviced as a read, array untouched
    txn(0, 1'b1, 1'b1, 32'h0000_0040, {32{8'h3C}});
    idle(3);
    txn(0, 1'b0, 1'b0, 32'h0000_0040, '0);
    idle(2);

    // Reset during BUSY of a write to index 3 aborts it
    x3 = {8{32'hDEAD_BEEF}};
    y3 = {8{32'h0BAD_F00D}};
    txn(0, 1'b1, 1'b0, 32'h0000_0060, x3);
    idle(1);
    rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h0000_0060; wdata[0] = y3;
    @(negedge clk);
    check("abort_resp_n", line_t'(resp[0]), '0);
    @(posedge clk); #1;
    rst = 1'b1; wr[0] = 1'b0;
    @(negedge clk);
    check("abort_resp_busy", line_t'(resp[0]), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    idle(6);
    txn(0, 1'b0, 1'b0, 32'hABCD_E07F, '0);
    check("abort_keeps_old", rdata[0], x3);
    idle(2);

    random_run(0, 30);
    idle(2);

    // Short-latency instance: reads answer in the next cycle
    txn(1, 1'b1, 1'b0, 32'h0000_00A0, {16{16'hC0DE}});
    idle(1);
    txn(1, 1'b0, 1'b0, 32'h7000_00BF, '0);
    idle(1);
    random_run(1, 15);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
